// File: rtl/lwb_pkg.sv
// Shared constants and helpers for the line window buffer.
package lwb_pkg;

  localparam int WIN_MAX = 5;
  localparam int COL_W   = 12;
  localparam int ROW_W   = 16;

  // Ceiling log2; values of 0 or 1 return 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line memory, one pixel per column. Combinational read of the
// stored word and a clocked write give read-before-write on the same address.
module line_ram
  import lwb_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents deliberately survive reset; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_window_buffer.sv
// Sliding WIN x WIN pixel window over a raster stream using WIN-1 line memories.
// Optional coordinate outputs (win_col/win_row) are built when LWB_COORD_OUT_EN is defined.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int LINE_WIDTH = 640,
  parameter int WIN        = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIX_W-1:0]         pixel_in,
  input  logic                     pixel_valid,
  input  logic                     sof,
  output logic [WIN*WIN*PIX_W-1:0] window_out,
  output logic                     window_valid
`ifdef LWB_COORD_OUT_EN
  ,
  output logic [COL_W-1:0]         win_col,
  output logic [ROW_W-1:0]         win_row
`endif
);

  localparam int ADDR_W = clog2(LINE_WIDTH);
  localparam int HALF   = (WIN - 1) / 2;

  if (!((WIN == 3) || (WIN == 5)) || (WIN > WIN_MAX)) begin : g_bad_win
    $error("line_window_buffer: WIN must be 3 or 5");
  end

  // pixel_valid is a one-way strobe: the pixel is consumed on every rising
  // edge where it is high, there is no ready, and sof only counts with it.

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             last_col;
  logic             take;

  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    last_col = (cur_col == COL_W'(LINE_WIDTH - 1));
    take     = pixel_valid && (cur_row >= ROW_W'(WIN - 1))
                           && (cur_col >= COL_W'(WIN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (last_col) begin
        col <= '0;
        row <= (cur_row == '1) ? cur_row : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line 0 is the oldest; each write pushes the displaced pixel one line older.
  logic [PIX_W-1:0] line_rd [WIN-1];
  logic [PIX_W-1:0] column  [WIN];

  for (genvar i = 0; i < WIN - 1; i++) begin : g_line
    logic [PIX_W-1:0] wdata;
    if (i == WIN - 2) begin : g_newest
      assign wdata = pixel_in;
    end else begin : g_older
      assign wdata = line_rd[i+1];
    end

    line_ram #(
      .PIX_W (PIX_W),
      .DEPTH (LINE_WIDTH)
    ) u_line_ram (
      .clk   (clk),
      .we    (pixel_valid),
      .addr  (cur_col[ADDR_W-1:0]),
      .wdata (wdata),
      .rdata (line_rd[i])
    );

    assign column[i] = line_rd[i];
  end

  assign column[WIN-1] = pixel_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_out <= '0;
    end else if (pixel_valid) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          window_out[(r*WIN+c)*PIX_W +: PIX_W] <= window_out[(r*WIN+c+1)*PIX_W +: PIX_W];
        end
        window_out[(r*WIN+WIN-1)*PIX_W +: PIX_W] <= column[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) window_valid <= 1'b0;
    else        window_valid <= take;
  end

`ifdef LWB_COORD_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_col <= '0;
      win_row <= '0;
    end else if (take) begin
      win_col <= cur_col - COL_W'(HALF);
      win_row <= cur_row - ROW_W'(HALF);
    end
  end
`endif

endmodule
